// File: rtl/shift_register.sv
// ---------------------------------------------------------------------------
// shift_register
//
// LED "fill then empty" chaser. Ones are shifted into the pattern from one
// side until every LED is lit. Zeros are then shifted in from the same side
// until every LED is dark, and the cycle repeats every 2*WIDTH steps.
// A step happens once every STEP_DIV clock cycles.
//
// Parameters:
//   WIDTH    - number of LEDs (>= 2)
//   STEP_DIV - clock cycles per pattern step (>= 1)
//
// Ports:
//   clk   - clock, all state changes on its rising edge
//   reset - synchronous, active-high reset; overrides every other input
//   lr    - direction: 1 = fill from the MSB side, 0 = fill from the LSB side
//   q     - LED pattern (bit WIDTH-1 is the leftmost LED), straight from a flop
// ---------------------------------------------------------------------------
module shift_register #(
  parameter int WIDTH    = 8,
  parameter int STEP_DIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lr,
  output logic [WIDTH-1:0] q
);

  // The prescaler needs at least one bit, even when STEP_DIV is 1.
  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(STEP_DIV - 1);

  typedef enum logic {
    FILL  = 1'b0,
    EMPTY = 1'b1
  } phase_t;

  phase_t          phase;
  phase_t          phase_nxt;
  logic            dir_q;
  logic            dir_nxt;
  logic [PW-1:0]   presc;
  logic [PW-1:0]   presc_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic            tick;

  // Shift one bit into the pattern. dir=1 enters at the MSB and moves the
  // pattern right; dir=0 enters at the LSB and moves the pattern left.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v,
                                                input logic             dir,
                                                input logic             b);
    if (dir) shift_in = {b, v[WIDTH-1:1]};
    else     shift_in = {v[WIDTH-2:0], b};
  endfunction

  assign tick = (presc == PMAX);

  // Next-state logic. A change on lr wins over a step tick that lands on the
  // same edge: the display is cleared and the prescaler restarts, so the first
  // 1 in the new direction appears a full step period later. If lr is steady,
  // the prescaler runs and the pattern only moves on a tick. The phase flips
  // when the pattern is full (FILL) or empty (EMPTY). The bit shifted in on
  // that same tick already belongs to the new phase.
  always_comb begin
    q_nxt     = q;
    phase_nxt = phase;
    dir_nxt   = dir_q;
    presc_nxt = presc;
    if (lr != dir_q) begin
      dir_nxt   = lr;
      q_nxt     = '0;
      phase_nxt = FILL;
      presc_nxt = '0;
    end else begin
      presc_nxt = tick ? '0 : presc + 1'b1;
      if (tick) begin
        case (phase)
          FILL: begin
            if (q == '1) begin
              phase_nxt = EMPTY;
              q_nxt     = shift_in(q, dir_q, 1'b0);
            end else begin
              q_nxt     = shift_in(q, dir_q, 1'b1);
            end
          end
          EMPTY: begin
            if (q == '0) begin
              phase_nxt = FILL;
              q_nxt     = shift_in(q, dir_q, 1'b1);
            end else begin
              q_nxt     = shift_in(q, dir_q, 1'b0);
            end
          end
          default: begin
            phase_nxt = FILL;
            q_nxt     = '0;
          end
        endcase
      end
    end
  end

  // State registers. Reset always returns to the left-to-right direction, so
  // that lr is ignored while reset is high (even if lr is X). If lr is 0 when
  // reset is released, the next edge goes through the normal restart.
  always_ff @(posedge clk) begin
    if (reset) begin
      q     <= '0;
      phase <= FILL;
      dir_q <= 1'b1;
      presc <= '0;
    end else begin
      q     <= q_nxt;
      phase <= phase_nxt;
      dir_q <= dir_nxt;
      presc <= presc_nxt;
    end
  end

endmodule

// File: tb/tb_shift_register.sv
// ---------------------------------------------------------------------------
// tb_shift_register
//
// Directed bench for shift_register. Three instances share the clock and
// reset:
//   dut8 - WIDTH=8, STEP_DIV=1 (main sequences, direction changes, reset)
//   dut3 - WIDTH=8, STEP_DIV=3 (each value is held for three cycles)
//   dut4 - WIDTH=4, STEP_DIV=1 (narrow instance, lr=0)
// Outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_shift_register;

  logic       clk = 1'b0;
  logic       reset;
  logic       lr8;
  logic       lr3;
  logic       lr4;
  logic [7:0] q8;
  logic [7:0] q3;
  logic [3:0] q4;

  int compared   = 0;
  int mismatched = 0;

  // Expected sequences for one full 16-step cycle with WIDTH=8.
  logic [7:0] seqL [16] = '{8'h00, 8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE,
                            8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01};
  logic [7:0] seqR [16] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                            8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};
  logic [3:0] seq4 [8]  = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

  shift_register #(.WIDTH(8), .STEP_DIV(1)) dut8 (
    .clk(clk), .reset(reset), .lr(lr8), .q(q8)
  );

  shift_register #(.WIDTH(8), .STEP_DIV(3)) dut3 (
    .clk(clk), .reset(reset), .lr(lr3), .q(q3)
  );

  shift_register #(.WIDTH(4), .STEP_DIV(1)) dut4 (
    .clk(clk), .reset(reset), .lr(lr4), .q(q4)
  );

  // Free-running clock with a period of 10.
  always #5 clk = ~clk;

  // Watchdog that ends the run if the directed sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: run did not finish, got timeout, wanted completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one rising edge, then step off the edge to sample outputs.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // One comparison: count it, and report it if it fails.
  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: got %h, wanted %h", tag, obs, exp);
    end
  endtask

  // Linear directed sequence covering the scenarios.
  initial begin
    // Reset with lr unknown on the main instance.
    reset = 1'b1;
    lr8   = 1'bx;
    lr3   = 1'b1;
    lr4   = 1'b0;
    applyStimulus();
    checkOutput("reset q8", q8, 8'h00);
    checkOutput("reset q3", q3, 8'h00);
    checkOutput("reset q4", {4'h0, q4}, 8'h00);

    // Scenario 1, plus STEP_DIV=3 and WIDTH=4 running in parallel.
    reset = 1'b0;
    lr8   = 1'b1;
    for (int i = 0; i < 160; i++) begin
      applyStimulus();
      checkOutput($sformatf("s1 q8 edge %0d", i + 1), q8, seqL[(i + 1) % 16]);
      checkOutput($sformatf("s5 q3 edge %0d", i + 1), q3, seqL[((i + 1) / 3) % 16]);
      checkOutput($sformatf("s6 q4 edge %0d", i + 1), {4'h0, q4}, {4'h0, seq4[i % 8]});
    end

    // Scenario 2: switch to right-to-left; the first edge clears the display.
    lr8 = 1'b0;
    for (int j = 0; j < 160; j++) begin
      applyStimulus();
      checkOutput($sformatf("s2 q8 edge %0d", j + 1), q8, seqR[j % 16]);
    end

    // Scenario 3: fill left-to-right up to F0, then reverse.
    lr8 = 1'b1;
    applyStimulus();
    checkOutput("s3 restart lr=1", q8, 8'h00);
    for (int m = 1; m <= 4; m++) begin
      applyStimulus();
      checkOutput($sformatf("s3 fill %0d", m), q8, seqL[m]);
    end
    lr8 = 1'b0;
    applyStimulus();
    checkOutput("s3 restart lr=0", q8, 8'h00);
    applyStimulus();
    checkOutput("s3 first 1", q8, 8'h01);
    applyStimulus();
    checkOutput("s3 second 1", q8, 8'h03);

    // A glitch on lr between edges must not restart the pattern.
    #2 lr8 = 1'b1;
    #2 lr8 = 1'b0;
    applyStimulus();
    checkOutput("glitch ignored", q8, 8'h07);

    // Scenario 4: reach 3F in EMPTY (left-to-right), then reset.
    lr8 = 1'b1;
    applyStimulus();
    checkOutput("s4 restart", q8, 8'h00);
    for (int m = 1; m <= 10; m++) begin
      applyStimulus();
      checkOutput($sformatf("s4 step %0d", m), q8, seqL[m]);
    end
    reset = 1'b1;
    applyStimulus();
    checkOutput("s4 reset abort", q8, 8'h00);
    reset = 1'b0;
    applyStimulus();
    checkOutput("s4 after release", q8, 8'h80);
    applyStimulus();
    checkOutput("s4 second step", q8, 8'hC0);

    // After reset with lr=0: first a restart edge, then 01, 03.
    reset = 1'b1;
    lr8   = 1'b0;
    applyStimulus();
    checkOutput("reset lr=0", q8, 8'h00);
    reset = 1'b0;
    applyStimulus();
    checkOutput("release lr=0 restart", q8, 8'h00);
    applyStimulus();
    checkOutput("release lr=0 01", q8, 8'h01);
    applyStimulus();
    checkOutput("release lr=0 03", q8, 8'h03);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
